// File: rtl/vga_frame_timing_out.sv
// 640x480@60 VGA timing generator and pixel sink in the pixel clock domain.
// Waits for a stable PLL lock, then streams RGB from a ready/valid/sop source.
module vga_frame_timing_out #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int LOCK_WAIT = 1024,
   parameter int DW        = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pll_locked,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_sop,
   output logic          in_ready,
   output logic [7:0]    vga_r,
   output logic [7:0]    vga_g,
   output logic [7:0]    vga_b,
   output logic          vga_hs,
   output logic          vga_vs,
   output logic          vga_blank_n,
   output logic          vga_sync_n,
   output logic          underflow,
   output logic          state_run
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int LW = $clog2(LOCK_WAIT + 1);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);

   typedef enum logic [1:0] {WAIT_LOCK, SYNC, RUN} state_t;

   state_t        state_q;
   logic          lock_s1_q, lock_s2_q;
   logic [LW-1:0] lock_cnt_q;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          hs_q, vs_q, blank_n_q;
   logic [DW-1:0] rgb_q;
   logic          underflow_q, pend_q;

   logic lock_ok, active, origin, h_last, v_last, frame_end;
   logic hs_win, vs_win, bad_sop, rdy, take, pix_ok;

   assign lock_ok   = lock_s2_q;
   assign h_last    = (h_q == H_LAST);
   assign v_last    = (v_q == V_LAST);
   assign frame_end = h_last && v_last;
   assign active    = (h_q < H_ACT) && (v_q < V_ACT);
   assign origin    = (h_q == '0) && (v_q == '0);
   assign hs_win    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
   assign vs_win    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
   assign bad_sop   = in_valid && in_sop && !origin;

   assign h_d = h_last ? '0 : h_q + 1'b1;
   assign v_d = !h_last ? v_q : (v_last ? '0 : v_q + 1'b1);

   // A misplaced sop is never consumed so the source keeps it for (0,0)
   always_comb begin
      rdy = 1'b0;
      unique case (state_q)
         SYNC:    rdy = !bad_sop;
         RUN:     rdy = active && !bad_sop;
         default: rdy = 1'b0;
      endcase
      if (!lock_ok) rdy = 1'b0;
   end

   assign take   = rdy && in_valid;
   assign pix_ok = take && ((state_q == RUN) || in_sop);

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_s1_q   <= 1'b0;
         lock_s2_q   <= 1'b0;
         state_q     <= WAIT_LOCK;
         lock_cnt_q  <= '0;
         h_q         <= '0;
         v_q         <= '0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         blank_n_q   <= 1'b0;
         rgb_q       <= '0;
         underflow_q <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         lock_s1_q <= pll_locked;
         lock_s2_q <= lock_s1_q;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
         if (!lock_ok) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            h_q        <= '0;
            v_q        <= '0;
            pend_q     <= 1'b0;
         end else begin
            unique case (state_q)
               WAIT_LOCK: begin
                  lock_cnt_q <= lock_cnt_q + 1'b1;
                  if (lock_cnt_q == LOCK_LAST) begin
                     lock_cnt_q <= '0;
                     state_q    <= SYNC;
                  end
               end
               SYNC: begin
                  if (take && in_sop) state_q <= RUN;
               end
               RUN: begin
                  if (active && bad_sop) begin
                     underflow_q <= 1'b1;
                     pend_q      <= 1'b0;
                     state_q     <= SYNC;
                  end else if (active && !in_valid) begin
                     underflow_q <= 1'b1;
                     pend_q      <= 1'b1;
                  end else if (frame_end && pend_q) begin
                     pend_q  <= 1'b0;
                     state_q <= SYNC;
                  end
               end
               default: state_q <= WAIT_LOCK;
            endcase
            if (state_q != WAIT_LOCK) begin
               h_q       <= h_d;
               v_q       <= v_d;
               hs_q      <= !hs_win;
               vs_q      <= !vs_win;
               blank_n_q <= active;
               if (pix_ok) rgb_q <= in_data;
            end
         end
      end
   end

   assign in_ready    = rdy;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign underflow   = underflow_q;
   assign state_run   = (state_q == RUN);

endmodule
